// File: rtl/order_tx_framer.sv
// Buffers orders from the tick-to-trade pipeline in a small FIFO and serializes
// each one into a 4-beat framed stream: header, word0, word1, checksum trailer.
module order_tx_framer #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] MAGIC      = 16'hA55A,
    parameter int          CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [63:0]                   in_word0,
    input  logic [63:0]                   in_word1,
    input  logic                          tx_enable,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [63:0]                   m_data,
    output logic                          m_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [CNT_W-1:0]              frames_sent
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, HDR, W0, W1, TRL} state_t;

    state_t        state, next_state;
    logic [127:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [63:0]   hold_w0, hold_w1;
    logic [31:0]   seq;
    logic          full, push, pop;
    logic [63:0]   header;
    logic [31:0]   checksum;

    // Full is judged on the registered level, so a same-cycle pop never frees a slot.
    assign full       = (level == LW'(FIFO_DEPTH));
    assign push       = in_valid && !full;
    assign fifo_level = level;

    assign header   = {MAGIC, seq, 8'h04, 8'h00};
    assign checksum = header[63:32] ^ header[31:0]
                    ^ hold_w0[63:32] ^ hold_w0[31:0]
                    ^ hold_w1[63:32] ^ hold_w1[31:0];

    // NOTE: payload storage has no reset; only pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_word1, in_word0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            hold_w0 <= '0;
            hold_w1 <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                hold_w0 <= mem[rd_ptr][63:0];
                hold_w1 <= mem[rd_ptr][127:64];
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: state and counters use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            seq         <= '0;
            drop_cnt    <= '0;
            frames_sent <= '0;
        end else begin
            state <= next_state;
            if (in_valid && full && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
            if (state == TRL && m_ready) begin
                seq         <= seq + 32'd1;
                frames_sent <= frames_sent + CNT_W'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0 && tx_enable) begin
                    pop        = 1'b1;
                    next_state = HDR;
                end
            end
            HDR: begin
                m_valid = 1'b1;
                m_data  = header;
                if (m_ready) next_state = W0;
            end
            W0: begin
                m_valid = 1'b1;
                m_data  = hold_w0;
                if (m_ready) next_state = W1;
            end
            W1: begin
                m_valid = 1'b1;
                m_data  = hold_w1;
                if (m_ready) next_state = TRL;
            end
            TRL: begin
                m_valid = 1'b1;
                m_data  = {32'h0, checksum};
                m_last  = 1'b1;
                if (m_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_order_tx_framer.sv
// Self-checking bench: an order-queue/frame-beat model predicts every output each
// cycle, and directed scenarios pin the model with hand-computed literals.
module tb_order_tx_framer;

    logic        clk, rst_n;
    logic        in_valid, tx_enable, m_ready;
    logic [63:0] in_word0, in_word1;
    logic        m_valid, m_last;
    logic [63:0] m_data;
    logic [3:0]  fifo_level;
    logic [15:0] drop_cnt, frames_sent;

    order_tx_framer #(.FIFO_DEPTH(8), .MAGIC(16'hA55A), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word0(in_word0),
        .in_word1(in_word1), .tx_enable(tx_enable), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt), .frames_sent(frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: queue of pending orders plus the four beats of the frame in flight.
    logic [127:0] mq[$];
    logic [63:0]  mbeats[4];
    int           midx;
    logic [31:0]  mseq;
    logic [15:0]  mdrop, mframes;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        midx    = -1;
        mseq    = 0;
        mdrop   = 0;
        mframes = 0;
    endtask

    task automatic model_step();
        int           pre;
        bit           push_ok;
        logic [127:0] e;
        logic [63:0]  hdr;
        logic [31:0]  cs;
        pre     = mq.size();
        push_ok = in_valid && (pre < 8);
        if (in_valid && !push_ok && mdrop != 16'hFFFF) mdrop++;
        if (midx < 0) begin
            if (pre != 0 && tx_enable) begin
                e   = mq.pop_front();
                hdr = {16'hA55A, mseq, 8'h04, 8'h00};
                cs  = hdr[63:32] ^ hdr[31:0] ^ e[63:32] ^ e[31:0] ^ e[127:96] ^ e[95:64];
                mbeats[0] = hdr;
                mbeats[1] = e[63:0];
                mbeats[2] = e[127:64];
                mbeats[3] = {32'h0, cs};
                midx = 0;
            end
        end else if (m_ready) begin
            if (midx == 3) begin
                mseq++;
                mframes++;
                midx = -1;
            end else begin
                midx++;
            end
        end
        if (push_ok) mq.push_back({in_word1, in_word0});
    endtask

    task automatic compare();
        check("m_valid", 64'(m_valid), 64'(midx >= 0));
        if (midx >= 0) begin
            check("m_data", m_data, mbeats[midx]);
            check("m_last", 64'(m_last), 64'(midx == 3));
        end
        check("fifo_level", 64'(fifo_level), 64'(mq.size()));
        check("drop_cnt", 64'(drop_cnt), 64'(mdrop));
        check("frames_sent", 64'(frames_sent), 64'(mframes));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_order(input logic [63:0] w0, input logic [63:0] w1);
        in_valid = 1'b1;
        in_word0 = w0;
        in_word1 = w1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        rst_n = 1'b0; in_valid = 1'b0; tx_enable = 1'b1; m_ready = 1'b1;
        in_word0 = '0; in_word1 = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_frames", 64'(frames_sent), 64'd0);
        compare();
        rst_n = 1'b1;

        // Single order with literal beats and latency.
        push_order(64'h0000_0001_0000_0002, 64'h0);
        check("lat_c1_level", 64'(fifo_level), 64'd1);
        check("lat_c1_valid", 64'(m_valid), 64'd0);
        tick();
        check("single_hdr", m_data, 64'hA55A_0000_0000_0400);
        check("single_hdr_valid", 64'(m_valid), 64'd1);
        tick();
        check("single_w0", m_data, 64'h0000_0001_0000_0002);
        tick();
        check("single_w1", m_data, 64'h0);
        tick();
        check("single_trl", m_data, 64'h0000_0000_A55A_0403);
        check("single_last", 64'(m_last), 64'd1);
        tick();
        check("single_frames", 64'(frames_sent), 64'd1);

        // Backpressure with alternating ready; second frame carries seq=1.
        seen = 1'b0;
        push_order({$urandom, $urandom}, {$urandom, $urandom});
        for (int i = 0; i < 14; i++) begin
            m_ready = ~m_ready;
            tick();
            if (m_valid && !seen) begin
                seen = 1'b1;
                check("bp_hdr_seq", 64'(m_data[47:16]), 64'd1);
            end
        end
        if (!seen) check("bp_hdr_seen", 64'd0, 64'd1);
        m_ready = 1'b1;
        ticks(6);
        check("bp_frames", 64'(frames_sent), 64'd2);

        // Overflow: 10 back-to-back orders while the stream is stalled.
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_word0 = {32'(i), $urandom};
            in_word1 = {$urandom, 32'(i)};
            tick();
        end
        in_valid = 1'b0;
        check("ovf_level", 64'(fifo_level), 64'd8);
        check("ovf_drop", 64'(drop_cnt), 64'd1);
        // Keep pushing through the frame end and the IDLE pop cycle: all dropped.
        m_ready  = 1'b1;
        in_valid = 1'b1;
        ticks(5);
        in_valid = 1'b0;
        check("popfull_drop", 64'(drop_cnt), 64'd6);
        check("popfull_level", 64'(fifo_level), 64'd7);
        ticks(60);
        check("ovf_drain_level", 64'(fifo_level), 64'd0);
        check("ovf_frames", 64'(frames_sent), 64'd11);

        // tx_enable dropped mid-frame, then orders wait until it returns.
        push_order({$urandom, $urandom}, {$urandom, $urandom});
        ticks(2);
        tx_enable = 1'b0;
        push_order({$urandom, $urandom}, {$urandom, $urandom});
        push_order({$urandom, $urandom}, {$urandom, $urandom});
        ticks(8);
        check("txen_idle_valid", 64'(m_valid), 64'd0);
        check("txen_level", 64'(fifo_level), 64'd2);
        check("txen_frames", 64'(frames_sent), 64'd12);
        tx_enable = 1'b1;
        ticks(2);
        check("txen_resume_valid", 64'(m_valid), 64'd1);
        ticks(15);

        // Asynchronous reset in the middle of a frame.
        push_order({$urandom, $urandom}, {$urandom, $urandom});
        ticks(3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(m_valid), 64'd0);
        check("arst_level", 64'(fifo_level), 64'd0);
        check("arst_drop", 64'(drop_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        compare();
        rst_n = 1'b1;
        push_order(64'h0000_0001_0000_0002, 64'h0);
        tick();
        check("arst_seq0_hdr", m_data, 64'hA55A_0000_0000_0400);
        ticks(5);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 40);
            in_word0  = {$urandom, $urandom};
            in_word1  = {$urandom, $urandom};
            m_ready   = ($urandom_range(0, 99) < 70);
            tx_enable = ($urandom_range(0, 99) < 90);
            tick();
        end
        in_valid = 1'b0; m_ready = 1'b1; tx_enable = 1'b1;
        ticks(80);
        check("final_level", 64'(fifo_level), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/order_tx_framer.md
Name: order_tx_framer

Overview:
Sits directly downstream of the tick-to-trade pipeline. Consumes its order output (valid + two 64-bit order words). The pipeline has no backpressure, so orders are buffered in a small FIFO. Each order is serialized into a 4-beat framed 64-bit valid/ready stream (header, word0, word1, trailer with checksum) toward the MAC/TX path.

Parameters:
FIFO_DEPTH, 8, order FIFO entries (power of two, >=2)
MAGIC, 16'hA55A, frame header magic
CNT_W, 16, width of drop and frame counters

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  order strobe from pipeline (no ready; one order per cycle max)
in_word0  input  64  order word 0
in_word1  input  64  order word 1
tx_enable  input  1  when low, no new frame starts
m_valid  output  1  stream beat valid
m_ready  input  1  downstream accept
m_data  output  64  stream beat
m_last  output  1  high on trailer beat
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
drop_cnt  output  CNT_W  orders dropped on full, saturating
frames_sent  output  CNT_W  frames fully accepted, wrapping

Behaviour:
- Reset is asynchronous and active-low: clk and rst_n, async assert, sync release. All outputs are 0 in reset, and FIFO, seq, FSM and counters are cleared. Reset mid-frame abandons the frame; no partial beats follow.
- FIFO write: on in_valid with fifo_level < FIFO_DEPTH, {in_word1,in_word0} is written and level increments next cycle.
- Full check: evaluated on the registered level before any same-cycle pop. If full, the order is dropped and drop_cnt increments, saturating at all-ones.
- Simultaneous push and pop leave level unchanged.
- FSM states: IDLE, HDR, W0, W1, TRL.
  - IDLE: if fifo_level != 0 and tx_enable=1, pop the head entry into a frame holding register, load the header beat, go to HDR. m_valid is asserted from the next cycle.
  - HDR -> W0 -> W1 -> TRL: each advance happens only on a cycle with m_valid && m_ready.
  - TRL: on acceptance, seq increments (32-bit wrap), frames_sent increments, and the FSM returns to IDLE. A pending entry starts the next frame on the following cycle, so there is one idle cycle between frames.
- tx_enable low does not interrupt a frame in progress. It only blocks leaving IDLE.
- Stream rule: once m_valid is high, m_data and m_last hold stable until accepted. m_valid never drops without acceptance. m_valid is low in IDLE.
- Beats:
  - Header: [63:48]=MAGIC, [47:16]=seq, [15:8]=8'h04 (beat count), [7:0]=8'h00.
  - W0: word0. W1: word1.
  - Trailer: [63:32]=0, [31:0]=checksum, with m_last=1.
  - checksum is the XOR of the upper and lower 32-bit halves of header, word0 and word1, computed from the holding register.
- Latency with an empty FIFO, IDLE, tx_enable=1, m_ready=1:
  - in_valid at cycle 0 -> entry visible at cycle 1 -> pop at cycle 1 -> header beat valid at cycle 2.
  - Trailer beat is at cycle 5.
- fifo_level reflects the registered count. Arithmetic wraps only where stated.

Test Plan:
- Single order: word0=64'h0000_0001_0000_0002, word1=0, seq=0, m_ready=1 -> beats A55A_0000_0000_0400, 0000_0001_0000_0002, 0, 0000_0000_A55A_0403 (m_last on beat 4); header at cycle 2; frames_sent=1.
- Backpressure: m_ready toggles 1010... during a frame -> each beat is held stable while m_valid=1 and m_ready=0, and the beat sequence is unchanged. A second frame carries seq=1 in header bits [47:16].
- Overflow: m_ready=0, then 10 consecutive in_valid pulses with FIFO_DEPTH=8 -> one entry is popped into the frame register on the 2nd cycle, so 9 are accepted; fifo_level=8 and drop_cnt=1. Release m_ready -> 9 frames come out in order.
- Push on full with same-cycle pop: level=8 at the TRL->IDLE pop cycle, plus in_valid -> the order is dropped and drop_cnt increments.
- tx_enable: deassert during W0 -> the frame completes. With orders queued and tx_enable=0, m_valid stays 0 and no pop occurs; reassert -> the next frame starts 2 cycles later.
- Reset mid-frame: rst_n low during W1 -> m_valid=0 immediately (async), fifo_level=0, drop_cnt=0, and seq restarts at 0 after release.
